// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer: state encoding, op codes, watchdog default.
package muldiv_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERROR = 3'd5;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int MAX_CYCLES_DEF = 40;

endpackage

// File: rtl/muldiv_watchdog.sv
// Saturating WAIT-cycle counter with terminal-count flag; used only when MULDIV_TIMEOUT_EN is defined.
module muldiv_watchdog
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int CNT_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (reset_in || clear) begin
      count <= '0;
    end else if (enable && !(&count)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Flag is raised during the last permitted WAIT cycle so a stop in that cycle still wins.
  assign tc = (count == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Moore FSM sequencing the shared multiplier/divider and HI/LO loads.
// Optional watchdog enabled by defining MULDIV_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a request
// START | one-cycle init strobe to the selected unit
// WAIT  | counting cycles until the selected unit stops
// WRITE | load HI/LO from the selected unit
// DONE  | completion pulse
// ERROR | divide-by-zero or watchdog pulse, no HI/LO load
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int CNT_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             req_valid,
  input  logic             req_op,
  output logic             req_ready,
  input  logic             mult_stop,
  input  logic             div_stop,
  input  logic             div_zero,
  output logic             mult_init,
  output logic             div_init,
  output logic             mux_high,
  output logic             mux_low,
  output logic             high_load,
  output logic             low_load,
  output logic             busy,
  output logic             done,
  output logic             div_zero_exc,
  output logic             timeout_exc,
  output logic [CNT_W-1:0] cycle_count
);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             op_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             tc;
  logic             sel_stop;
  logic             div_by_zero;

  assign sel_stop    = (op_q == OP_DIV) ? div_stop : mult_stop;
  assign div_by_zero = (op_q == OP_DIV) && div_zero;
  assign cnt_inc     = (&cnt) ? cnt : cnt + CNT_W'(1);

`ifdef MULDIV_TIMEOUT_EN
  logic err_to;

  muldiv_watchdog #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .reset_in (reset_in),
    .clear    (state == START),
    .enable   (state == WAIT),
    .count    (cnt),
    .tc       (tc)
  );

  // Remember why ERROR was entered so the right exception pulses.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      err_to <= 1'b0;
    end else if (state_nxt == ERROR && state != ERROR) begin
      err_to <= (state == WAIT) && !div_by_zero;
    end
  end

  assign div_zero_exc = (state == ERROR) && !err_to;
  assign timeout_exc  = (state == ERROR) && err_to;
`else
  assign tc = 1'b0;

  always_ff @(posedge clk) begin
    if (reset_in || state == START) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt_inc;
    end
  end

  assign div_zero_exc = (state == ERROR);
  assign timeout_exc  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid) state_nxt = (req_op == OP_DIV && div_zero) ? ERROR : START;
      START: state_nxt = WAIT;
      WAIT: begin
        if (div_by_zero)   state_nxt = ERROR;
        else if (sel_stop) state_nxt = WRITE;
        else if (tc)       state_nxt = ERROR;
      end
      WRITE: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      ERROR: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state       <= IDLE;
      op_q        <= OP_MULT;
      cycle_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) op_q <= req_op;
      if (state == WAIT && state_nxt == WRITE) cycle_count <= cnt_inc;
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign mult_init = (state == START) && (op_q == OP_MULT);
  assign div_init  = (state == START) && (op_q == OP_DIV);
  assign high_load = (state == WRITE);
  assign low_load  = (state == WRITE);
  assign mux_high  = (state == WRITE) && op_q;
  assign mux_low   = (state == WRITE) && op_q;
  assign done      = (state == DONE);

endmodule
